systolic_input_feeder: RTL and testbench

Front-end streamer for the systolic matrix-multiply array. It buffers one operand matrix A and one operand matrix B, both loaded row by row over a valid/ready handshake. On start, it emits the diagonally skewed row/column vectors the array consumes, one vector pair per cycle. It also emits the array's accumulator-clear pulse, the valid strobe and the active matrix size. It sits directly upstream of the array's i_a_full/i_b_full/i_valid/i_reset/XYZ inputs.

---
 rtl/systolic_input_feeder.sv | 160 ++++++++++++++++
 tb/tb_systolic_input_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: buffers operand matrices A and B, then streams
// diagonally skewed lane vectors, accumulator clear, valid and size to the
// systolic array.
// Optional feature macro: SYSTOLIC_FEEDER_REPEAT_EN (adds i_repeat; a run
// started with i_repeat=1 returns to READY with the buffers retained).
module systolic_input_feeder #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned I_BITS   = 8,
  parameter int unsigned CNT_BITS = $clog2(3*SIZE)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_load_valid,
  output logic                   o_load_ready,
  input  logic [SIZE*I_BITS-1:0] i_load_data,
  input  logic                   i_start,
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
  input  logic                   i_repeat,
`endif
  input  logic [2:0]             i_size,
  output logic [SIZE*I_BITS-1:0] o_a_full,
  output logic [SIZE*I_BITS-1:0] o_b_full,
  output logic                   o_valid,
  output logic                   o_pe_reset,
  output logic [2:0]             o_size,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned ROW_W   = $clog2(2*SIZE);
  localparam int unsigned LANES_W = SIZE*I_BITS;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM} state_t;

  state_t               state;
  logic [ROW_W-1:0]     row_cnt;
  logic [CNT_BITS-1:0]  beat_cnt;
  logic [I_BITS-1:0]    a_buf [SIZE][SIZE];
  logic [I_BITS-1:0]    b_buf [SIZE][SIZE];
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
  logic                 repeat_q;
`endif

  logic                 load_fire_c;
  logic [2:0]           size_clamped_c;
  logic [CNT_BITS-1:0]  beat_last_c;
  logic [LANES_W-1:0]   a_skew_c;
  logic [LANES_W-1:0]   b_skew_c;

  // Handshake, requested-size clamp and final beat index of the current run
  always_comb begin
    load_fire_c    = (state == S_LOAD) && i_load_valid && o_load_ready;
    size_clamped_c = (i_size == 3'd0 || i_size > 3'(SIZE)) ? 3'(SIZE) : i_size;
    beat_last_c    = CNT_BITS'(3*int'(o_size) - 2);
  end

  // Diagonal skew: lane k of A carries row k delayed by k beats; B lane
  // SIZE-1-c carries column c delayed by c beats; inactive lanes are zero
  always_comb begin
    int d;
    d        = 0;
    a_skew_c = '0;
    b_skew_c = '0;
    for (int k = 0; k < SIZE; k++) begin
      d = int'(beat_cnt) - k;
      if (k < int'(o_size) && d >= 0 && d < int'(o_size)) begin
        a_skew_c[k*I_BITS +: I_BITS]          = a_buf[IDX_W'(k)][IDX_W'(d)];
        b_skew_c[(SIZE-1-k)*I_BITS +: I_BITS] = b_buf[IDX_W'(d)][IDX_W'(k)];
      end
    end
  end

  // Operand buffers: first SIZE beats fill A rows, next SIZE beats fill B rows
  always_ff @(posedge i_clock) begin
    if (!i_reset && load_fire_c) begin
      for (int c = 0; c < SIZE; c++) begin
        if (row_cnt < ROW_W'(SIZE))
          a_buf[IDX_W'(row_cnt)][IDX_W'(c)] <= i_load_data[c*I_BITS +: I_BITS];
        else
          b_buf[IDX_W'(row_cnt - ROW_W'(SIZE))][IDX_W'(c)] <= i_load_data[c*I_BITS +: I_BITS];
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= S_LOAD;
      row_cnt      <= '0;
      beat_cnt     <= '0;
      o_load_ready <= 1'b1;
      o_a_full     <= '0;
      o_b_full     <= '0;
      o_valid      <= 1'b0;
      o_pe_reset   <= 1'b0;
      o_size       <= 3'(SIZE);
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
      repeat_q     <= 1'b0;
`endif
    end else begin
      o_pe_reset <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        S_LOAD: begin
          if (load_fire_c) begin
            if (row_cnt == ROW_W'(2*SIZE-1)) begin
              row_cnt      <= '0;
              o_load_ready <= 1'b0;
              state        <= S_READY;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        S_READY: begin
          if (i_start) begin
            o_size     <= size_clamped_c;
            o_pe_reset <= 1'b1;
            o_busy     <= 1'b1;
            beat_cnt   <= '0;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
            repeat_q   <= i_repeat;
`endif
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (beat_cnt == beat_last_c) begin
            o_valid  <= 1'b0;
            o_a_full <= '0;
            o_b_full <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
`ifdef SYSTOLIC_FEEDER_REPEAT_EN
            if (repeat_q) begin
              state <= S_READY;
            end else begin
              state        <= S_LOAD;
              o_load_ready <= 1'b1;
            end
`else
            state        <= S_LOAD;
            o_load_ready <= 1'b1;
`endif
          end else begin
            o_valid  <= 1'b1;
            o_a_full <= a_skew_c;
            o_b_full <= b_skew_c;
            beat_cnt <= beat_cnt + CNT_BITS'(1);
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed self-checking bench for systolic_input_feeder (default build).
module tb_systolic_input_feeder;

  localparam int unsigned SIZE   = 4;
  localparam int unsigned I_BITS = 8;
  localparam int unsigned W      = SIZE*I_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         start;
  logic [2:0]   size_in;
  logic [W-1:0] a_full;
  logic [W-1:0] b_full;
  logic         valid;
  logic         pe_reset;
  logic [2:0]   size_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int fails  = 0;

  logic [7:0]   ma [4][4];
  logic [7:0]   mb [4][4];
  logic [W-1:0] a_seen [16];
  logic [W-1:0] b_seen [16];

  systolic_input_feeder #(.SIZE(SIZE), .I_BITS(I_BITS)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_load_valid(load_valid), .o_load_ready(load_ready), .i_load_data(load_data),
    .i_start(start), .i_size(size_in),
    .o_a_full(a_full), .o_b_full(b_full), .o_valid(valid),
    .o_pe_reset(pe_reset), .o_size(size_out), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lanes straight from the skew definition
  function automatic logic [W-1:0] exp_a(input int t, input int n);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (k < n && t - k >= 0 && t - k < n) r[k*8 +: 8] = ma[k][t-k];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_b(input int t, input int n);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      if (c < n && t - c >= 0 && t - c < n) r[(3-c)*8 +: 8] = mb[t-c][c];
    return r;
  endfunction

  function automatic logic [W-1:0] row_word(input int r);
    logic [W-1:0] d;
    for (int c = 0; c < 4; c++) d[c*8 +: 8] = (r < 4) ? ma[r][c] : mb[r-4][c];
    return d;
  endfunction

  task automatic load_beat(input int r);
    load_valid = 1'b1;
    load_data  = row_word(r);
    step();
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < 8; r++) load_beat(r);
    chk("ready_after_load", 64'(load_ready), 64'd0);
  endtask

  // Start a run and check every cycle through o_done; optional start poke mid-stream
  task automatic run_stream(input logic [2:0] sz, input int n, input bit poke);
    size_in = sz;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk("pe_reset_t1", 64'(pe_reset), 64'd1);
    chk("busy_t1", 64'(busy), 64'd1);
    chk("valid_t1", 64'(valid), 64'd0);
    chk("size_out", 64'(size_out), 64'(n));
    for (int t = 0; t < 3*n - 2; t++) begin
      start = (poke && t == 2);
      step();
      chk("valid_beat", 64'(valid), 64'd1);
      chk("pe_reset_beat", 64'(pe_reset), 64'd0);
      chk("done_early", 64'(done), 64'd0);
      chk("a_beat", 64'(a_full), 64'(exp_a(t, n)));
      chk("b_beat", 64'(b_full), 64'(exp_b(t, n)));
      a_seen[t] = a_full;
      b_seen[t] = b_full;
    end
    start = 1'b0;
    step();
    chk("done_pulse", 64'(done), 64'd1);
    chk("valid_end", 64'(valid), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("a_end", 64'(a_full), 64'd0);
    step();
    chk("done_clear", 64'(done), 64'd0);
    chk("ready_back", 64'(load_ready), 64'd1);
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'(4*r + c + 1);
        mb[r][c] = (r == c) ? 8'd1 : 8'd0;
      end
    rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; size_in = 3'd4;
    step();
    step();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_a", 64'(a_full), 64'd0);
    chk("rst_b", 64'(b_full), 64'd0);
    chk("rst_pe_reset", 64'(pe_reset), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_size", 64'(size_out), 64'd4);
    chk("rst_ready", 64'(load_ready), 64'd1);
    rst = 1'b0;

    // Full-size run with hand-computed beats
    load_all();
    run_stream(3'd4, 4, 1'b0);
    chk("t0_a", 64'(a_seen[0]), 64'h0000_0001);
    chk("t0_b", 64'(b_seen[0]), 64'h0100_0000);
    chk("t2_b", 64'(b_seen[2]), 64'h0001_0000);
    chk("t3_a", 64'(a_seen[3]), 64'h0D0A_0704);
    chk("t3_b", 64'(b_seen[3]), 64'h0000_0000);
    chk("t6_a", 64'(a_seen[6]), 64'h1000_0000);
    chk("t9_a", 64'(a_seen[9]), 64'h0000_0000);

    // Reduced size N=2
    load_all();
    run_stream(3'd2, 2, 1'b0);
    chk("n2_t1_a", 64'(a_seen[1]), 64'h0000_0502);
    chk("n2_t1_b", 64'(b_seen[1]), 64'h0000_0000);

    // Size clamping
    load_all();
    run_stream(3'd0, 4, 1'b0);
    load_all();
    run_stream(3'd6, 4, 1'b0);

    // Reset in the middle of a stream
    load_all();
    size_in = 3'd4;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_valid_before", 64'(valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", 64'(valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(load_ready), 64'd1);
    chk("mid_a", 64'(a_full), 64'd0);
    chk("mid_size", 64'(size_out), 64'd4);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mid_no_done", 64'(done), 64'd0);
      chk("mid_idle_valid", 64'(valid), 64'd0);
    end

    // Start ignored in LOAD and STREAM; load beats ignored in READY
    ma[2][1] = 8'hA5;
    mb[1][2] = 8'h3C;
    for (int r = 0; r < 3; r++) load_beat(r);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_start_busy", 64'(busy), 64'd0);
    chk("load_start_pe", 64'(pe_reset), 64'd0);
    chk("load_start_ready", 64'(load_ready), 64'd1);
    for (int r = 3; r < 8; r++) load_beat(r);
    chk("ready_state", 64'(load_ready), 64'd0);
    load_valid = 1'b1;
    load_data  = '1;
    step();
    step();
    load_valid = 1'b0;
    chk("ready_still_low", 64'(load_ready), 64'd0);
    chk("ready_idle_busy", 64'(busy), 64'd0);
    run_stream(3'd4, 4, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
